// File: rtl/punc_control_if.sv
// Control bus between the PUnC controller and its datapath: ir and flags in, every control strobe out.
// Purely combinational wiring; no handshake, the controller drives every strobe every cycle.
interface punc_control_if;
  logic [15:0] ir;
  logic        n;
  logic        z;
  logic        p;
  logic        mem_w_en;
  logic        mem_w_addr_sel;
  logic [1:0]  mem_r_addr_sel;
  logic        rf_w_en;
  logic        rf_r0_addr_sel;
  logic        rf_r1_addr_sel;
  logic [1:0]  rf_w_data_sel;
  logic        rf_w_addr_sel;
  logic        ir_ld;
  logic        pc_ld;
  logic        pc_clr;
  logic        pc_inc;
  logic [1:0]  pc_ld_data_sel;
  logic [2:0]  alu_sel;
  logic        cond_ld;
  logic        cond_ld_data_sel;

  modport master (
    input  ir, n, z, p,
    output mem_w_en, mem_w_addr_sel, mem_r_addr_sel, rf_w_en, rf_r0_addr_sel,
           rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel, ir_ld, pc_ld, pc_clr,
           pc_inc, pc_ld_data_sel, alu_sel, cond_ld, cond_ld_data_sel
  );

  modport slave (
    output ir, n, z, p,
    input  mem_w_en, mem_w_addr_sel, mem_r_addr_sel, rf_w_en, rf_r0_addr_sel,
           rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel, ir_ld, pc_ld, pc_clr,
           pc_inc, pc_ld_data_sel, alu_sel, cond_ld, cond_ld_data_sel
  );
endinterface

// File: rtl/punc_control.sv
// PUnC LC3 control FSM: fetch/decode/execute sequencing plus retired-instruction count and halt flag.
// 3 cycles per instruction (4 for LDI/STI); no backpressure, strobes are combinational from state and ir/nzp.
module punc_control #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  punc_control_if.master    bus,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_ADD_I = 3'd1;
  localparam logic [2:0] ALU_NOT   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_AND_I = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  logic [3:0] opcode;
  logic       br_taken;
  logic       two_step;

  assign opcode   = bus.ir[15:12];
  assign br_taken = (bus.ir[11] & bus.n) | (bus.ir[10] & bus.z) | (bus.ir[9] & bus.p);
  assign two_step = (opcode == OP_LDI) || (opcode == OP_STI);
  assign halted   = (state == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_INIT;
      instr_count <= '0;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= (opcode == OP_HALT) ? S_HALT : S_EXEC;
        S_EXEC: begin
          if (two_step) begin
            state <= S_EXEC2;
          end else begin
            state       <= S_FETCH;
            instr_count <= instr_count + CNT_ONE;
          end
        end
        S_EXEC2: begin
          state       <= S_FETCH;
          instr_count <= instr_count + CNT_ONE;
        end
        S_HALT:   state <= S_HALT;
        default:  state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    bus.mem_w_en         = 1'b0;
    bus.mem_w_addr_sel   = 1'b0;
    bus.mem_r_addr_sel   = 2'd0;
    bus.rf_w_en          = 1'b0;
    bus.rf_r0_addr_sel   = 1'b0;
    bus.rf_r1_addr_sel   = 1'b0;
    bus.rf_w_data_sel    = 2'd0;
    bus.rf_w_addr_sel    = 1'b0;
    bus.ir_ld            = 1'b0;
    bus.pc_ld            = 1'b0;
    bus.pc_clr           = 1'b0;
    bus.pc_inc           = 1'b0;
    bus.pc_ld_data_sel   = 2'd0;
    bus.alu_sel          = 3'd0;
    bus.cond_ld          = 1'b0;
    bus.cond_ld_data_sel = 1'b0;
    case (state)
      S_INIT: bus.pc_clr = 1'b1;
      S_FETCH: begin
        bus.ir_ld  = 1'b1;
        bus.pc_inc = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            bus.rf_w_en = 1'b1;
            bus.cond_ld = 1'b1;
            if (opcode == OP_NOT)      bus.alu_sel = ALU_NOT;
            else if (opcode == OP_ADD) bus.alu_sel = bus.ir[5] ? ALU_ADD_I : ALU_ADD;
            else                       bus.alu_sel = bus.ir[5] ? ALU_AND_I : ALU_AND;
          end
          OP_BR: bus.pc_ld = br_taken;
          OP_JMP: begin
            bus.pc_ld          = 1'b1;
            bus.pc_ld_data_sel = 2'd1;
          end
          // R7 takes the pre-jump pc because the write and the pc load share one edge.
          OP_JSR: begin
            bus.rf_w_en        = 1'b1;
            bus.rf_w_data_sel  = 2'd2;
            bus.rf_w_addr_sel  = 1'b1;
            bus.pc_ld          = 1'b1;
            bus.pc_ld_data_sel = bus.ir[11] ? 2'd2 : 2'd1;
          end
          OP_LD, OP_LDR: begin
            bus.mem_r_addr_sel   = (opcode == OP_LD) ? 2'd1 : 2'd2;
            bus.rf_w_en          = 1'b1;
            bus.rf_w_data_sel    = 2'd1;
            bus.cond_ld          = 1'b1;
            bus.cond_ld_data_sel = 1'b1;
          end
          OP_LEA: begin
            bus.rf_w_en          = 1'b1;
            bus.rf_w_data_sel    = 2'd3;
            bus.cond_ld          = 1'b1;
            bus.cond_ld_data_sel = 1'b1;
          end
          OP_ST, OP_STR: begin
            bus.mem_w_en       = 1'b1;
            bus.mem_w_addr_sel = (opcode == OP_STR);
            bus.rf_r1_addr_sel = 1'b1;
          end
          OP_LDI, OP_STI: bus.mem_r_addr_sel = 2'd1;
          default: ;
        endcase
      end
      S_EXEC2: begin
        if (opcode == OP_LDI) begin
          bus.mem_r_addr_sel   = 2'd3;
          bus.rf_w_en          = 1'b1;
          bus.rf_w_data_sel    = 2'd1;
          bus.cond_ld          = 1'b1;
          bus.cond_ld_data_sel = 1'b1;
        end else begin
          // Pointer stays presented so the datapath can route mem_r_data as the store address.
          bus.mem_r_addr_sel = 2'd1;
          bus.mem_w_en       = 1'b1;
          bus.rf_r1_addr_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
